// File: rtl/serial_operand_loader.sv
// Deserialises two 8-bit operands from a 1-bit stream and issues one start pulse per frame.
// Define SERIAL_LOADER_PARITY_EN to add a 17th even-parity bit and the parity_err output.
module serial_operand_loader #(
  parameter int HOLD_CYCLES = 4,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ser_valid,
  input  logic       ser_data,
  input  logic       flush,
  output logic       ser_ready,
  output logic [7:0] operand1,
  output logic [7:0] operand2,
  output logic       start,
  output logic       busy,
  output logic [7:0] frame_cnt
`ifdef SERIAL_LOADER_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [3:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

`ifdef SERIAL_LOADER_PARITY_EN
  typedef enum logic [2:0] {RX_OP1, RX_OP2, RX_PAR, ISSUE, HOLD} state_t;
`else
  typedef enum logic [2:0] {RX_OP1, RX_OP2, ISSUE, HOLD} state_t;
`endif

  state_t     state, state_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [7:0] sr1, sr1_d, sr2, sr2_d;
  logic [3:0] hold_cnt, hold_d;
  logic [7:0] op1_d, op2_d, fc_d;
  logic       perr_d, start_d, busy_d, rx, accept;

  // New bits enter at the end that leaves the first-received bit in its final position.
  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
    return LSB_FIRST ? {b, sr[7:1]} : {sr[6:0], b};
  endfunction

  assign rx     = (state != ISSUE) && (state != HOLD);
  assign accept = ser_valid & ser_ready;

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    sr1_d     = sr1;
    sr2_d     = sr2;
    hold_d    = hold_cnt;
    op1_d     = operand1;
    op2_d     = operand2;
    fc_d      = frame_cnt;
    perr_d    = 1'b0;
    if (rx && flush) begin
      state_d   = RX_OP1;
      bit_cnt_d = 3'd0;
      sr1_d     = 8'd0;
      sr2_d     = 8'd0;
    end else begin
      case (state)
        RX_OP1: if (accept) begin
          sr1_d     = shift_in(sr1, ser_data);
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = RX_OP2;
        end
        RX_OP2: if (accept) begin
          sr2_d     = shift_in(sr2, ser_data);
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef SERIAL_LOADER_PARITY_EN
            state_d = RX_PAR;
`else
            state_d = ISSUE;
            op1_d   = sr1;
            op2_d   = sr2_d;
            fc_d    = frame_cnt + 8'd1;
`endif
          end
        end
`ifdef SERIAL_LOADER_PARITY_EN
        RX_PAR: if (accept) begin
          if (ser_data == ^{sr1, sr2}) begin
            state_d = ISSUE;
            op1_d   = sr1;
            op2_d   = sr2;
            fc_d    = frame_cnt + 8'd1;
          end else begin
            state_d = RX_OP1;
            perr_d  = 1'b1;
            sr1_d   = 8'd0;
            sr2_d   = 8'd0;
          end
        end
`endif
        ISSUE: begin
          if (HOLD_CYCLES == 0) state_d = RX_OP1;
          else begin
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (hold_cnt == 4'd0) state_d = RX_OP1;
          else hold_d = hold_cnt - 4'd1;
        end
        default: state_d = RX_OP1;
      endcase
    end
    start_d = (state_d == ISSUE);
    busy_d  = (state_d == ISSUE) || (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RX_OP1;
      bit_cnt   <= 3'd0;
      sr1       <= 8'd0;
      sr2       <= 8'd0;
      hold_cnt  <= 4'd0;
      operand1  <= 8'd0;
      operand2  <= 8'd0;
      frame_cnt <= 8'd0;
      start     <= 1'b0;
      busy      <= 1'b0;
      ser_ready <= 1'b1;
`ifdef SERIAL_LOADER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      sr1       <= sr1_d;
      sr2       <= sr2_d;
      hold_cnt  <= hold_d;
      operand1  <= op1_d;
      operand2  <= op2_d;
      frame_cnt <= fc_d;
      start     <= start_d;
      busy      <= busy_d;
      ser_ready <= !busy_d;
`ifdef SERIAL_LOADER_PARITY_EN
      parity_err <= perr_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_operand_loader.sv
// Bench for serial_operand_loader: an LSB-first and an MSB-first instance share one stream.
module tb_serial_operand_loader;
  localparam int HOLD = 4;

  logic clk = 1'b0, reset_n = 1'b0, ser_valid = 1'b0, ser_data = 1'b0, flush = 1'b0;
  logic ser_ready, start, busy, ready_b, start_b, busy_b;
  logic [7:0] operand1, operand2, frame_cnt, op1_b, op2_b, fc_b;
`ifdef SERIAL_LOADER_PARITY_EN
  logic parity_err, perr_b;
`endif

  int checks = 0, failures = 0, starts_seen = 0, exp_starts = 0;
  logic [7:0] exp_op1 = 8'd0, exp_op2 = 8'd0, exp_fc = 8'd0;

  always #5 clk = ~clk;
  always @(negedge clk) if (start === 1'b1) starts_seen++;

  serial_operand_loader #(.HOLD_CYCLES(HOLD), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ser_valid(ser_valid), .ser_data(ser_data), .flush(flush),
    .ser_ready(ser_ready), .operand1(operand1), .operand2(operand2), .start(start),
    .busy(busy), .frame_cnt(frame_cnt)
`ifdef SERIAL_LOADER_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  serial_operand_loader #(.HOLD_CYCLES(HOLD), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset_n(reset_n), .ser_valid(ser_valid), .ser_data(ser_data), .flush(flush),
    .ser_ready(ready_b), .operand1(op1_b), .operand2(op2_b), .start(start_b),
    .busy(busy_b), .frame_cnt(fc_b)
`ifdef SERIAL_LOADER_PARITY_EN
    , .parity_err(perr_b)
`endif
  );

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic send_bit(input logic b, input bit gaps);
    bit sent = 1'b0;
    while (!sent) begin
      @(negedge clk);
      checks++;
      if (ser_ready !== 1'b1) begin failures++; $display("FAIL rx_ready got=%b want=1", ser_ready); end
      if (gaps && $urandom_range(2) == 0) begin
        ser_valid = 1'b0;
        ser_data  = 1'($urandom);
      end else begin
        ser_valid = 1'b1;
        ser_data  = b;
        sent      = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input bit gaps, input bit flush_hold);
    int low;
    for (int i = 0; i < 16; i++) send_bit((i < 8) ? a[i] : b[i-8], gaps);
`ifdef SERIAL_LOADER_PARITY_EN
    send_bit(^{a, b}, gaps);
`endif
    @(negedge clk);
    ser_valid = 1'b0;
    exp_op1 = a; exp_op2 = b; exp_fc = exp_fc + 8'd1; exp_starts++;
    checks += 8;
    if (start !== 1'b1) begin failures++; $display("FAIL start got=%b want=1", start); end
    if (operand1 !== exp_op1) begin failures++; $display("FAIL op1 got=%h want=%h", operand1, exp_op1); end
    if (operand2 !== exp_op2) begin failures++; $display("FAIL op2 got=%h want=%h", operand2, exp_op2); end
    if (op1_b !== rev8(a)) begin failures++; $display("FAIL op1_msb got=%h want=%h", op1_b, rev8(a)); end
    if (op2_b !== rev8(b)) begin failures++; $display("FAIL op2_msb got=%h want=%h", op2_b, rev8(b)); end
    if (frame_cnt !== exp_fc || fc_b !== exp_fc) begin failures++; $display("FAIL frame_cnt got=%h/%h want=%h", frame_cnt, fc_b, exp_fc); end
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_issue got=%b want=1", busy); end
    if (ser_ready !== 1'b0) begin failures++; $display("FAIL ready_issue got=%b want=0", ser_ready); end
    flush = flush_hold;
    low = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ser_ready === 1'b1) break;
      low++;
    end
    flush = 1'b0;
    checks += 3;
    if (low != 1 + HOLD) begin failures++; $display("FAIL ready_low_cycles got=%0d want=%0d", low, 1 + HOLD); end
    if (starts_seen != exp_starts) begin failures++; $display("FAIL start_count got=%0d want=%0d", starts_seen, exp_starts); end
    if (operand1 !== exp_op1 || operand2 !== exp_op2) begin failures++; $display("FAIL op_stable got=%h/%h want=%h/%h", operand1, operand2, exp_op1, exp_op2); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (operand1 !== 8'd0 || operand2 !== 8'd0) begin failures++; $display("FAIL reset_ops got=%h/%h want=00/00", operand1, operand2); end
    if (frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_fc got=%h want=00", frame_cnt); end
    if (start !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_ctl got=%b%b want=00", start, busy); end
`ifdef SERIAL_LOADER_PARITY_EN
    if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b want=0", parity_err); end
`else
    if (op1_b !== 8'd0) begin failures++; $display("FAIL reset_op1_msb got=%h want=00", op1_b); end
`endif
    reset_n = 1'b1;
    exp_op1 = 8'd0; exp_op2 = 8'd0; exp_fc = 8'd0;
    @(negedge clk);
    checks++;
    if (ser_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b want=1", ser_ready); end
  endtask

  task automatic test_frame();
    send_frame(8'h5A, 8'hC3, 1'b0, 1'b0);
    send_frame(8'h01, 8'h80, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    repeat (12) send_frame(8'($urandom), 8'($urandom), 1'b1, 1'($urandom_range(1)));
  endtask

  task automatic test_flush();
    logic [7:0] a = 8'($urandom), b = 8'($urandom);
    for (int i = 0; i < 10; i++) send_bit((i < 8) ? a[i] : b[i-8], 1'b0);
    @(negedge clk);
    ser_valid = 1'b1; ser_data = b[2]; flush = 1'b1;
    @(negedge clk);
    ser_valid = 1'b0; flush = 1'b0;
    checks += 4;
    if (start !== 1'b0) begin failures++; $display("FAIL flush_start got=%b want=0", start); end
    if (operand1 !== exp_op1 || operand2 !== exp_op2) begin failures++; $display("FAIL flush_ops got=%h/%h want=%h/%h", operand1, operand2, exp_op1, exp_op2); end
    if (frame_cnt !== exp_fc) begin failures++; $display("FAIL flush_fc got=%h want=%h", frame_cnt, exp_fc); end
    if (ser_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL flush_ctl got=%b%b want=10", ser_ready, busy); end
    send_frame(8'($urandom), 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 11; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    ser_valid = 1'b1; ser_data = 1'b1; reset_n = 1'b0;
    #1;
    exp_op1 = 8'd0; exp_op2 = 8'd0; exp_fc = 8'd0;
    checks += 3;
    if (operand1 !== 8'd0 || operand2 !== 8'd0 || op1_b !== 8'd0 || op2_b !== 8'd0) begin failures++; $display("FAIL midreset_ops got=%h/%h want=00/00", operand1, operand2); end
    if (frame_cnt !== 8'd0 || fc_b !== 8'd0) begin failures++; $display("FAIL midreset_fc got=%h want=00", frame_cnt); end
    if (start !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_ctl got=%b%b want=00", start, busy); end
    @(negedge clk);
    ser_valid = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ser_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b want=1", ser_ready); end
    send_frame(8'h3C, 8'h96, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    test_reset();
    repeat (256) send_frame(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    checks++;
    if (frame_cnt !== 8'd0) begin failures++; $display("FAIL wrap_fc got=%h want=00", frame_cnt); end
  endtask

`ifdef SERIAL_LOADER_PARITY_EN
  task automatic test_parity();
    logic [7:0] a = 8'hFF, b = 8'h01;
    for (int i = 0; i < 16; i++) send_bit((i < 8) ? a[i] : b[i-8], 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    ser_valid = 1'b0;
    checks += 2;
    if (parity_err !== 1'b1 || perr_b !== 1'b1) begin failures++; $display("FAIL perr_pulse got=%b want=1", parity_err); end
    if (start !== 1'b0) begin failures++; $display("FAIL perr_start got=%b want=0", start); end
    @(negedge clk);
    checks += 3;
    if (parity_err !== 1'b0) begin failures++; $display("FAIL perr_width got=%b want=0", parity_err); end
    if (operand1 !== exp_op1 || operand2 !== exp_op2 || frame_cnt !== exp_fc) begin failures++; $display("FAIL perr_hold got=%h/%h/%h want=%h/%h/%h", operand1, operand2, frame_cnt, exp_op1, exp_op2, exp_fc); end
    if (starts_seen != exp_starts) begin failures++; $display("FAIL perr_starts got=%0d want=%0d", starts_seen, exp_starts); end
    send_frame(8'($urandom), 8'($urandom), 1'b0, 1'b0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame();
    test_random();
    test_flush();
    test_reset_midframe();
`ifdef SERIAL_LOADER_PARITY_EN
    test_parity();
`endif
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_operand_loader.md
SERIAL_OPERAND_LOADER -- requirements
Module: serial_operand_loader

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: idle cycles after each start pulse before the next frame is accepted; range 0-15.
REQ-002 Parameter LSB_FIRST, default 1: 1 means the first received bit of each operand is bit 0; 0 means it is bit 7.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port ser_valid, input, 1: ser_data carries a valid bit this cycle.
REQ-006 Port ser_data, input, 1: serial operand bit.
REQ-007 Port ser_ready, output, 1: loader accepts a bit this cycle.
REQ-008 Port flush, input, 1: synchronous discard of any partially received frame.
REQ-009 Port operand1, output, 8: first operand of the last issued frame, feeding the downstream serial adder.
REQ-010 Port operand2, output, 8: second operand of the last issued frame.
REQ-011 Port start, output, 1: one-cycle pulse requesting a downstream add.
REQ-012 Port busy, output, 1: high in ISSUE and HOLD.
REQ-013 Port frame_cnt, output, 8: count of issued frames.

Function
REQ-014 A bit is accepted on a rising edge where ser_valid and ser_ready are both 1; ser_data is ignored otherwise.
REQ-015 The state machine has states RX_OP1, RX_OP2, RX_PAR (present only with PARITY_EN), ISSUE and HOLD.
REQ-016 ser_ready is 1 in RX_OP1, RX_OP2 and RX_PAR, and 0 in ISSUE and HOLD.
REQ-017 Each RX_OPn state collects 8 accepted bits into an internal shift register and moves on after the 8th bit; a 3-bit bit counter wraps 7->0.
REQ-018 With LSB_FIRST=1, bits shift in at the MSB end and move toward bit 0; with LSB_FIRST=0, bits shift in at bit 0 and move toward the MSB.
REQ-019 On the edge that completes the frame, operand1 and operand2 load from the shift registers, state becomes ISSUE, and start is 1 for exactly that ISSUE cycle.
REQ-020 operand1 and operand2 change only on the edge entering ISSUE and stay stable until the next such edge, so downstream may sample operand2 late.
REQ-021 ISSUE moves to HOLD with the hold counter loaded to HOLD_CYCLES-1; HOLD returns to RX_OP1 when the counter reaches 0.
REQ-022 With HOLD_CYCLES=0, ISSUE returns directly to RX_OP1; minimum frame period is 17 cycles, or 18 with parity.
REQ-023 frame_cnt increments by 1 on each start pulse and wraps 255->0.
REQ-024 In RX states, flush clears the bit counter and shift registers and returns to RX_OP1; flush wins over a simultaneous bit accept, and operand outputs are unchanged.
REQ-025 In ISSUE and HOLD, flush is ignored.
REQ-026 All outputs are registered; start never asserts twice without an intervening complete frame.

Reset
REQ-027 While reset_n=0, state is RX_OP1, and operand1, operand2, frame_cnt, the bit counter, the hold counter and the shift registers are all 0.
REQ-028 While reset_n=0, start and busy are 0.
REQ-029 ser_ready is 1 from the first clock after reset_n deasserts.
REQ-030 Reset asserted mid-frame or during HOLD aborts immediately with no start pulse.

Configuration
REQ-031 With macro SERIAL_LOADER_PARITY_EN defined, a 17th bit received in RX_PAR is checked as even parity over all 16 operand bits.
REQ-032 With SERIAL_LOADER_PARITY_EN defined, a parity match proceeds to ISSUE.
REQ-033 With SERIAL_LOADER_PARITY_EN defined, a mismatch returns to RX_OP1 with no start, operands unchanged and frame_cnt unchanged, and output parity_err pulses for 1 cycle.
REQ-034 Without SERIAL_LOADER_PARITY_EN, the RX_PAR state and the parity_err port do not exist, and the frame is 16 bits.

Verification
REQ-035 Frame test: LSB_FIRST=1, continuous valid, bits of 0x5A then 0xC3 -> start pulses once, operand1=0x5A, operand2=0xC3, frame_cnt=1, ser_ready=0 for exactly 1+4 cycles.
REQ-036 Bit-order test: LSB_FIRST=0, same bit stream -> operand1=0x5A bit-reversed=0x5A? use 0x01/0x80 -> operand1=0x80, operand2=0x01.
REQ-037 Flush test: flush asserted together with the 11th bit -> no start, outputs hold the previous frame, and the next 16 bits form a fresh frame.
REQ-038 Reset test: reset_n low at bit 12 of a frame -> all outputs 0, no start, normal frame accepted afterwards.
REQ-039 Wrap and parity test: 256 frames -> frame_cnt=0; with SERIAL_LOADER_PARITY_EN, a 0xFF/0x01 frame with parity bit 0 -> parity_err pulse and no start.
